// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, DATA_WIDTH data bits LSB first, optional parity, stop).
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 3-sample majority around mid-bit.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_in,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [5:0]            r_edge_cnt;
    logic [5:0]            r_presc;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_armed;
    logic                  r_par_bad;
    logic                  r_stop_bit;

    logic                  w_rx_s;
    logic [5:0]            w_mid;
    logic                  w_last;
    logic                  w_take;
    logic                  w_bit;

    assign w_rx_s = r_sync2;
    assign w_mid  = r_presc >> 1;
    assign w_last = (r_edge_cnt == (r_presc - 6'd1));

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_v0;
    logic r_v1;

    // Bit is decided one edge late, once the third sample is on the line.
    assign w_take = (r_edge_cnt == (w_mid + 6'd1));
    assign w_bit  = (r_v0 & r_v1) | (r_v0 & w_rx_s) | (r_v1 & w_rx_s);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v0 <= 1'b1;
            r_v1 <= 1'b1;
        end else begin
            if (r_edge_cnt == (w_mid - 6'd1)) r_v0 <= w_rx_s;
            if (r_edge_cnt == w_mid)          r_v1 <= w_rx_s;
        end
    end
`else
    assign w_take = (r_edge_cnt == w_mid);
    assign w_bit  = w_rx_s;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_presc    <= 6'd16;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_armed    <= 1'b1;
            r_par_bad  <= 1'b0;
            r_stop_bit <= 1'b1;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            r_edge_cnt <= w_last ? 6'd0 : (r_edge_cnt + 6'd1);

            case (r_state)
                S_IDLE: begin
                    r_edge_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (w_rx_s) r_armed <= 1'b1;
                    if (r_armed && !w_rx_s) begin
                        r_state   <= S_START;
                        r_presc   <= prescale;
                        r_par_en  <= par_en;
                        r_par_typ <= par_typ;
                        r_par_bad <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_take && w_bit) r_state <= S_IDLE;
                    else if (w_last)     r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_take) r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                    if (w_last) begin
                        if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_take) r_par_bad <= w_bit ^ (^r_shift) ^ r_par_typ;
                    if (w_last) r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_take) r_stop_bit <= w_bit;
                    if (w_last) begin
                        if (!r_stop_bit || r_par_bad) begin
                            par_err <= r_par_bad;
                            stp_err <= !r_stop_bit;
                        end else begin
                            p_data     <= r_shift;
                            data_valid <= 1'b1;
                        end
                        // A good stop with the line already low is the next start bit:
                        // enter START here so back-to-back frames lose no cycle.
                        if (r_stop_bit && !w_rx_s) begin
                            r_state   <= S_START;
                            r_presc   <= prescale;
                            r_par_en  <= par_en;
                            r_par_typ <= par_typ;
                            r_par_bad <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_armed <= r_stop_bit;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have port clk  input  1  oversampling clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rx_in  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port prescale  input  6  clocks per bit; legal values 8, 16, 32.
REQ-006 SHALL have port par_en  input  1  1 = parity bit present after data.
REQ-007 SHALL have port par_typ  input  1  0 = even, 1 = odd parity.
REQ-008 SHALL have port p_data  output  DATA_WIDTH  last good received word.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse, p_data updated.
REQ-010 SHALL have port par_err  output  1  one-cycle pulse, parity mismatch.
REQ-011 SHALL have port stp_err  output  1  one-cycle pulse, stop bit sampled 0.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer; all timing below refers to the synchronized line (rx_s).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, all outputs registered.
REQ-014 SHALL use an edge counter 0..prescale-1 per bit and a bit counter 0..DATA_WIDTH-1.
REQ-015 IDLE: when armed and rx_s = 0, SHALL go to START and clear both counters.
REQ-016 IDLE: SHALL latch prescale, par_en and par_typ on that same cycle; mid-frame changes have no effect.
REQ-017 START: SHALL sample at edge count prescale/2; if sample = 1, SHALL return to IDLE with no flags (glitch reject).
REQ-018 START: with sample = 0, SHALL enter DATA at edge count prescale-1.
REQ-019 DATA: SHALL sample each bit at prescale/2 and shift it in LSB first.
REQ-020 DATA: after bit DATA_WIDTH-1 completes, SHALL go to PARITY if par_en = 1, else STOP.
REQ-021 PARITY: SHALL compare the sample with the XOR of the data bits (inverted when par_typ = 1) and hold the mismatch internally.
REQ-022 STOP: SHALL sample at prescale/2 and go to IDLE at edge count prescale-1.
REQ-023 End of STOP, no errors: SHALL load p_data and pulse data_valid for exactly one cycle.
REQ-024 End of STOP, errors: SHALL pulse par_err and/or stp_err, assert no data_valid, and leave p_data unchanged.
REQ-025 SHALL re-arm in IDLE immediately after a good stop bit, so back-to-back frames receive with zero idle gap.
REQ-026 After stp_err, SHALL re-arm only after at least one rx_s = 1 cycle; a held-low break line yields exactly one stp_err.
REQ-027 Frame latency: data_valid SHALL assert (1 + DATA_WIDTH + par_en + 1) x prescale cycles after the first rx_s = 0 cycle.
REQ-028 Illegal prescale values: behaviour undefined; the FSM SHALL still always return to IDLE within one frame time.

Reset
REQ-029 rstn low SHALL asynchronously force IDLE, armed, counters 0, shift register 0, p_data 0, data_valid 0, par_err 0, stp_err 0, synchronizer flops 1.
REQ-030 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL be received correctly.

Configuration
REQ-031 Macro UART_RX_MAJORITY_VOTE_EN defined: each bit value SHALL be the majority of samples at edge counts prescale/2-1, prescale/2 and prescale/2+1.
REQ-032 Macro undefined: SHALL use a single sample at prescale/2; the vote logic SHALL not be present; all other timing is identical.

Verification
REQ-033 prescale = 16, par_en = 0, frame 0xA5 -> p_data = 0xA5, one data_valid pulse 160 cycles after the start edge, no error flags.
REQ-034 prescale = 8, par_en = 1, par_typ = 0: 0x3C with parity 0 -> data_valid; the same frame with parity 1 -> par_err pulse, no data_valid, p_data still 0x3C.
REQ-035 prescale = 16, 0x55 with stop bit = 0 then line held low for 100 cycles -> exactly one stp_err; next frame 0x12 -> p_data = 0x12.
REQ-036 Low pulse of 4 cycles at prescale = 16 -> no flags, FSM back in IDLE; back-to-back frames 0x55, 0xAA at prescale = 8 -> two data_valid pulses exactly 80 cycles apart.
REQ-037 rstn asserted during DATA bit 3, released, then frame 0xF0 -> all outputs 0 during reset, then p_data = 0xF0.
REQ-038 One-cycle high glitch on rx_s at the mid-sample of data bit 0, prescale = 16 -> bit read as 0 with UART_RX_MAJORITY_VOTE_EN defined, as 1 without it.
